// File: rtl/exp3_apresentador_sequencia.sv
// Plays the stored reference sequence on the LEDs before a round: each ROM entry
// is lit for TEMPO_ON cycles, followed by a blank gap of TEMPO_OFF cycles.
module exp3_apresentador_sequencia #(
  parameter int TEMPO_ON   = 1000,
  parameter int TEMPO_OFF  = 250,
  parameter int N_POSICOES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  output logic [3:0] leds,
  output logic       apresentando,
  output logic       pronto,
  output logic [3:0] db_endereco,
  output logic [3:0] db_estado
);

  localparam int TMAX = (TEMPO_ON > TEMPO_OFF) ? TEMPO_ON : TEMPO_OFF;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ON_LAST   = TW'(TEMPO_ON - 1);
  localparam logic [TW-1:0] OFF_LAST  = TW'(TEMPO_OFF - 1);
  localparam logic [3:0]    ADDR_LAST = 4'(N_POSICOES - 1);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    MOSTRA     = 4'h2,
    APAGA      = 4'h3,
    PROXIMO    = 4'h4,
    FIM        = 4'hF
  } estado_t;

  estado_t       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    addr_q, addr_d;

  // Same sequence contents as the switch-comparison datapath ROM.
  function automatic logic [3:0] rom_read(input logic [3:0] a);
    logic [3:0] v;
    case (a)
      4'h0: v = 4'h1;
      4'h1: v = 4'h2;
      4'h2: v = 4'h4;
      4'h3: v = 4'h8;
      4'h4: v = 4'h4;
      4'h5: v = 4'h2;
      4'h6: v = 4'h1;
      4'h7: v = 4'h1;
      4'h8: v = 4'h2;
      4'h9: v = 4'h2;
      4'hA: v = 4'h4;
      4'hB: v = 4'h4;
      4'hC: v = 4'h8;
      4'hD: v = 4'h8;
      4'hE: v = 4'h1;
      4'hF: v = 4'h4;
      default: v = 4'h0;
    endcase
    return v;
  endfunction

  // State, timer and address registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      timer_q <= '0;
      addr_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; iniciar is only looked at in inicial and fim.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    case (state_q)
      INICIAL: begin
        if (iniciar) state_d = PREPARACAO;
        else         state_d = INICIAL;
      end
      PREPARACAO: begin
        addr_d  = 4'h0;
        timer_d = '0;
        state_d = MOSTRA;
      end
      MOSTRA: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = APAGA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      APAGA: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          // The address stops at the last entry instead of wrapping.
          if (addr_q == ADDR_LAST) state_d = FIM;
          else                     state_d = PROXIMO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PROXIMO: begin
        addr_d  = addr_q + 4'h1;
        state_d = MOSTRA;
      end
      FIM: begin
        if (iniciar) state_d = PREPARACAO;
        else         state_d = FIM;
      end
      default: begin
        state_d = INICIAL;
        timer_d = '0;
        addr_d  = 4'h0;
      end
    endcase
  end

  // Moore output decode from the registered state and address.
  always_comb begin
    leds         = 4'h0;
    apresentando = 1'b0;
    pronto       = 1'b0;
    case (state_q)
      MOSTRA: begin
        leds         = rom_read(addr_q);
        apresentando = 1'b1;
      end
      APAGA:   apresentando = 1'b1;
      PROXIMO: apresentando = 1'b1;
      FIM:     pronto       = 1'b1;
      default: begin
        leds         = 4'h0;
        apresentando = 1'b0;
        pronto       = 1'b0;
      end
    endcase
  end

  assign db_endereco = addr_q;
  assign db_estado   = state_q;

endmodule

// File: tb/tb_exp3_apresentador_sequencia.sv
// Directed bench: instance A (3/2/4) for play, restart and reset cases,
// instance B (1/1/16) for the full-length sequence.
module tb_exp3_apresentador_sequencia;

  localparam logic [3:0] ROM_T [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  logic       clk = 1'b0;
  logic       rst_a_n, ini_a, rst_b_n, ini_b;
  logic [3:0] leds_a, addr_a, est_a, leds_b, addr_b, est_b;
  logic       apres_a, pronto_a, apres_b, pronto_b;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  exp3_apresentador_sequencia #(.TEMPO_ON(3), .TEMPO_OFF(2), .N_POSICOES(4)) dut_a (
    .clock(clk), .reset(rst_a_n), .iniciar(ini_a), .leds(leds_a),
    .apresentando(apres_a), .pronto(pronto_a), .db_endereco(addr_a), .db_estado(est_a));

  exp3_apresentador_sequencia #(.TEMPO_ON(1), .TEMPO_OFF(1), .N_POSICOES(16)) dut_b (
    .clock(clk), .reset(rst_b_n), .iniciar(ini_b), .leds(leds_b),
    .apresentando(apres_b), .pronto(pronto_b), .db_endereco(addr_b), .db_estado(est_b));

  wire [13:0] obs_a = {leds_a, apres_a, pronto_a, addr_a, est_a};
  wire [13:0] obs_b = {leds_b, apres_b, pronto_b, addr_b, est_b};

  // Expected {leds, apresentando, pronto, db_endereco, db_estado} after edge k,
  // where edge 0 samples iniciar.
  function automatic logic [13:0] model(input int k, input int on, input int off,
                                         input int n, input logic [3:0] prep_addr);
    logic [3:0] l, ad, st;
    logic       ap, pr;
    int         j, e, r;
    l = 4'h0; ap = 1'b0; pr = 1'b0; ad = 4'h0; st = 4'h0;
    if (k == 0) begin
      ad = prep_addr; st = 4'h1;
    end else if (k >= n * (on + off) + n) begin
      ad = 4'(n - 1); st = 4'hF; pr = 1'b1;
    end else begin
      j = k - 1; e = j / (on + off + 1); r = j % (on + off + 1);
      ad = 4'(e); ap = 1'b1;
      if (r < on) begin
        st = 4'h2; l = ROM_T[e];
      end else if (r < on + off) begin
        st = 4'h3;
      end else begin
        st = 4'h4;
      end
    end
    return {l, ap, pr, ad, st};
  endfunction

  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0; ini_a = 1'b0; ini_b = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ini_a = ~ini_a; ini_b = ~ini_b;
      #1;
      n_checks++;
      if (obs_a !== 14'h0 || obs_b !== 14'h0) begin
        n_fail++;
        $display("FAIL reset_values i=%0d got a=%h b=%h want 0000", i, obs_a, obs_b);
      end
    end
    @(negedge clk);
    ini_a = 1'b0; ini_b = 1'b0; rst_a_n = 1'b1; rst_b_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_a !== 14'h0 || obs_b !== 14'h0) begin
        n_fail++;
        $display("FAIL idle_after_reset i=%0d got a=%h b=%h want 0000", i, obs_a, obs_b);
      end
    end
  endtask

  task automatic test_full_play();
    logic [13:0] exp_v;
    @(negedge clk) ini_a = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      if (k == 0) ini_a = 1'b0;
      exp_v = model(k, 3, 2, 4, 4'h0);
      n_checks++;
      if (obs_a !== exp_v) begin
        n_fail++;
        $display("FAIL full_play k=%0d got %h want %h", k, obs_a, exp_v);
      end
    end
  endtask

  task automatic test_replay_from_fim();
    logic [13:0] exp_v;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (pronto_a !== 1'b1 || est_a !== 4'hF) begin
        n_fail++;
        $display("FAIL fim_hold i=%0d got pronto=%b st=%h want 1 F", i, pronto_a, est_a);
      end
    end
    ini_a = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      if (k == 0) ini_a = 1'b0;
      exp_v = model(k, 3, 2, 4, 4'h3);
      n_checks++;
      if (obs_a !== exp_v) begin
        n_fail++;
        $display("FAIL replay k=%0d got %h want %h", k, obs_a, exp_v);
      end
    end
  endtask

  task automatic test_ignored_restart();
    logic [13:0] exp_v;
    @(negedge clk) ini_a = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      if (k == 0 || k == 10) ini_a = 1'b0;
      if (k == 9) ini_a = 1'b1;
      exp_v = model(k, 3, 2, 4, 4'h3);
      n_checks++;
      if (obs_a !== exp_v) begin
        n_fail++;
        $display("FAIL ignored_restart k=%0d got %h want %h", k, obs_a, exp_v);
      end
    end
  endtask

  task automatic test_mid_run_reset();
    logic [13:0] exp_v;
    @(negedge clk) ini_a = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k == 0) ini_a = 1'b0;
      exp_v = model(k, 3, 2, 4, 4'h3);
      n_checks++;
      if (obs_a !== exp_v) begin
        n_fail++;
        $display("FAIL mid_run_pre k=%0d got %h want %h", k, obs_a, exp_v);
      end
    end
    #1 rst_a_n = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== 14'h0) begin
      n_fail++;
      $display("FAIL mid_run_async_reset got %h want 0000", obs_a);
    end
    @(negedge clk) rst_a_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_a !== 14'h0) begin
        n_fail++;
        $display("FAIL mid_run_stay_inicial i=%0d got %h want 0000", i, obs_a);
      end
    end
  endtask

  task automatic test_full_length();
    logic [13:0] exp_v;
    @(negedge clk) ini_b = 1'b1;
    for (int k = 0; k <= 52; k++) begin
      @(negedge clk);
      if (k == 0) ini_b = 1'b0;
      exp_v = model(k, 1, 1, 16, 4'h0);
      n_checks++;
      if (obs_b !== exp_v) begin
        n_fail++;
        $display("FAIL full_length k=%0d got %h want %h", k, obs_b, exp_v);
      end
    end
    n_checks++;
    if (addr_b !== 4'hF || pronto_b !== 1'b1) begin
      n_fail++;
      $display("FAIL full_length_end got addr=%h pronto=%b want F 1", addr_b, pronto_b);
    end
  endtask

  initial begin
    test_reset();
    test_full_play();
    test_replay_from_fim();
    test_ignored_restart();
    test_mid_run_reset();
    test_full_length();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
